// File: rtl/pf_io_dly_pkg.sv
// rtl/pf_io_dly_pkg.sv - shared types and constants for the PF_IO dynamic delay-line controller
package pf_io_dly_pkg;

    localparam int   CNT_W   = 4;
    localparam logic DIR_INC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LSETTLE,
        ST_EVAL,
        ST_DIRSET,
        ST_MOVE,
        ST_SETTLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pf_io_dly_wait_cnt.sv
// rtl/pf_io_dly_wait_cnt.sv - loadable 4-bit down-counter with zero flag for the delay-line wait states
module pf_io_dly_wait_cnt
    import pf_io_dly_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Loading N-1 gives a wait of exactly N cycles, the last one seeing zero=1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pf_io_dly_ctrl.sv
// rtl/pf_io_dly_ctrl.sv - PF_IO dynamic delay-line tap sequencer; optional stats via PF_IO_DLY_CTRL_STATS_EN
module pf_io_dly_ctrl
    import pf_io_dly_pkg::*;
#(
    parameter int TAP_W         = 8,
    parameter int MAX_TAP       = 255,
    parameter int LOAD_TAP      = 1,
    parameter int DIR_SETUP_CYC = 1,
    parameter int SETTLE_CYC    = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [TAP_W-1:0] REQ_TAP,
    input  logic             REQ_LOAD,
    output logic             DONE,
    output logic             DONE_ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             CUR_VALID,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE
`ifdef PF_IO_DLY_CTRL_STATS_EN
    ,
    output logic [15:0]      MOVE_CNT,
    output logic [7:0]       ERR_CNT
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DIRSET_LD = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [TAP_W:0]   MAX_EXT   = (TAP_W+1)'(MAX_TAP);

    state_t           state;
    state_t           state_d;
    logic             ready_en;
    logic [TAP_W-1:0] target;
    logic [TAP_W-1:0] cur_tap;
    logic             cur_valid;
    logic             dir;
    logic             err;

    logic             accept;
    logic             req_bad;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    // ready_en keeps REQ_READY low for the first cycle after reset releases
    assign REQ_READY = ready_en && (state == ST_IDLE);
    assign accept    = REQ_VALID && REQ_READY;
    assign req_bad   = {1'b0, REQ_TAP} > MAX_EXT;

    pf_io_dly_wait_cnt u_wait_cnt (
        .clk      (CLK),
        .resetn   (RESET_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_DONE;
                    end else if (REQ_LOAD || !cur_valid) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_LOAD: begin
                state_d  = ST_LSETTLE;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
            end
            ST_LSETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (target == cur_tap) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_DIRSET;
                    cnt_load = 1'b1;
                    cnt_val  = DIRSET_LD;
                end
            end
            ST_DIRSET: begin
                if (cnt_zero) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                state_d  = ST_SETTLE;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    if (DELAY_LINE_OUT_OF_RANGE || (cur_tap == target)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            ready_en  <= 1'b0;
            target    <= '0;
            cur_tap   <= '0;
            cur_valid <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_d;
            ready_en <= 1'b1;
            if (accept) begin
                target <= REQ_TAP;
                err    <= req_bad;
            end
            case (state)
                ST_LOAD: begin
                    cur_tap   <= TAP_W'(LOAD_TAP);
                    cur_valid <= 1'b1;
                end
                ST_EVAL: begin
                    if (target != cur_tap) begin
                        dir <= (target > cur_tap) ? DIR_INC : ~DIR_INC;
                    end
                end
                ST_MOVE: begin
                    // target is range-checked, so stepping toward it never wraps
                    if (dir == DIR_INC) begin
                        cur_tap <= cur_tap + TAP_W'(1);
                    end else begin
                        cur_tap <= cur_tap - TAP_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero && DELAY_LINE_OUT_OF_RANGE) begin
                        cur_valid <= 1'b0;
                        err       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign DONE                 = (state == ST_DONE);
    assign DONE_ERR             = (state == ST_DONE) && err;
    assign CUR_TAP              = cur_tap;
    assign CUR_VALID            = cur_valid;
    assign DELAY_LINE_LOAD      = (state == ST_LOAD);
    assign DELAY_LINE_MOVE      = (state == ST_MOVE);
    assign DELAY_LINE_DIRECTION = dir;

`ifdef PF_IO_DLY_CTRL_STATS_EN
    logic [15:0] move_cnt;
    logic [7:0]  err_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            move_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if ((state == ST_MOVE) && (move_cnt != 16'hFFFF)) begin
                move_cnt <= move_cnt + 16'd1;
            end
            if (DONE_ERR && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign MOVE_CNT = move_cnt;
    assign ERR_CNT  = err_cnt;
`endif

endmodule

// File: tb/tb_pf_io_dly_ctrl.sv
// tb/tb_pf_io_dly_ctrl.sv - self-checking bench for pf_io_dly_ctrl against a latency/tap reference model
module tb_pf_io_dly_ctrl;

    localparam int TAP_W    = 8;
    localparam int MAX_TAP  = 100;
    localparam int LOAD_TAP = 1;
    localparam int DS       = 1;
    localparam int SC       = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             req_valid;
    logic             req_ready;
    logic [TAP_W-1:0] req_tap;
    logic             req_load;
    logic             done;
    logic             done_err;
    logic [TAP_W-1:0] cur_tap;
    logic             cur_valid;
    logic             dl_load;
    logic             dl_move;
    logic             dl_dir;
    logic             dl_oor;
`ifdef PF_IO_DLY_CTRL_STATS_EN
    logic [15:0]      move_cnt;
    logic [7:0]       err_cnt;
    int               m_moves_total = 0;
    int               m_errs_total  = 0;
`endif

    int checks = 0;
    int errors = 0;
    int m_tap   = 0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    pf_io_dly_ctrl #(
        .TAP_W         (TAP_W),
        .MAX_TAP       (MAX_TAP),
        .LOAD_TAP      (LOAD_TAP),
        .DIR_SETUP_CYC (DS),
        .SETTLE_CYC    (SC)
    ) dut (
        .CLK                     (clk),
        .RESET_N                 (resetn),
        .REQ_VALID               (req_valid),
        .REQ_READY               (req_ready),
        .REQ_TAP                 (req_tap),
        .REQ_LOAD                (req_load),
        .DONE                    (done),
        .DONE_ERR                (done_err),
        .CUR_TAP                 (cur_tap),
        .CUR_VALID               (cur_valid),
        .DELAY_LINE_LOAD         (dl_load),
        .DELAY_LINE_MOVE         (dl_move),
        .DELAY_LINE_DIRECTION    (dl_dir),
        .DELAY_LINE_OUT_OF_RANGE (dl_oor)
`ifdef PF_IO_DLY_CTRL_STATS_EN
        ,
        .MOVE_CNT                (move_cnt),
        .ERR_CNT                 (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int tap, input bit load);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_tap   = TAP_W'(tap);
        req_load  = load;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_tap   = TAP_W'($urandom);
        req_load  = 1'($urandom);
    endtask

    // Model: latency, pulse counts and final tap derived from target distance
    task automatic run_req(input int tap, input bit load, input int oor_k, input string tag);
        int  exp_lat, exp_moves, exp_loads, start, d, pre;
        bit  exp_err, exp_dir, do_load;
        int  lat, moves, loads, viol, dir_bad;
        bit  prev_pulse, got_err;
        logic [TAP_W-1:0] tap_at_done;
        logic valid_at_done;

        exp_dir = 1'b0;
        if (tap > MAX_TAP) begin
            exp_lat = 1; exp_err = 1'b1; exp_moves = 0; exp_loads = 0;
        end else begin
            do_load   = load || !m_valid;
            start     = do_load ? LOAD_TAP : m_tap;
            exp_loads = do_load ? 1 : 0;
            d         = (tap > start) ? tap - start : start - tap;
            exp_dir   = (tap > start);
            pre       = do_load ? 1 + SC : 0;
            if (oor_k > 0 && oor_k <= d) begin
                exp_moves = oor_k; exp_err = 1'b1;
                exp_lat   = pre + 2 + DS + oor_k * (1 + SC);
            end else begin
                exp_moves = d; exp_err = 1'b0;
                exp_lat   = (d == 0) ? pre + 2 : pre + 2 + DS + d * (1 + SC);
            end
        end

        launch(tap, load);
        lat = 0; moves = 0; loads = 0; viol = 0; dir_bad = 0;
        prev_pulse = 1'b0; got_err = 1'b0; tap_at_done = '0; valid_at_done = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (dl_load || dl_move) begin
                if (prev_pulse || (dl_load && dl_move)) viol++;
            end
            prev_pulse = dl_load || dl_move;
            if (dl_load) loads++;
            if (dl_move) begin
                moves++;
                if (dl_dir !== exp_dir) dir_bad++;
                if (oor_k > 0 && moves == oor_k) dl_oor = 1'b1;
            end
            if (done) begin
                lat           = c;
                got_err       = done_err;
                tap_at_done   = cur_tap;
                valid_at_done = cur_valid;
                break;
            end
        end
        dl_oor = 1'b0;

        if (tap <= MAX_TAP) begin
            if (exp_err) m_valid = 1'b0;
            else begin
                m_tap   = tap;
                m_valid = 1'b1;
            end
        end

        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_loads"}, 32'(loads), 32'(exp_loads));
        check({tag, "_moves"}, 32'(moves), 32'(exp_moves));
        check({tag, "_pulse_spacing"}, 32'(viol), 32'd0);
        check({tag, "_direction"}, 32'(dir_bad), 32'd0);
        check({tag, "_cur_valid"}, 32'(valid_at_done), 32'(m_valid));
        if (m_valid) check({tag, "_cur_tap"}, 32'(tap_at_done), 32'(m_tap));
`ifdef PF_IO_DLY_CTRL_STATS_EN
        m_moves_total += exp_moves;
        if (exp_err) m_errs_total++;
        check({tag, "_move_cnt"}, 32'(move_cnt), 32'(m_moves_total));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_errs_total));
`endif
    endtask

    initial begin
        int w, done_seen, tap;
        bit ld;
        int ok;

        resetn    = 1'b0;
        req_valid = 1'b0;
        req_tap   = '0;
        req_load  = 1'b0;
        dl_oor    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'({done, done_err}), 32'd0);
        check("rst_cur_tap", 32'(cur_tap), 32'd0);
        check("rst_cur_valid", 32'(cur_valid), 32'd0);
        check("rst_pulses", 32'({dl_load, dl_move, dl_dir}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        run_req(5, 1'b0, 0, "up_from_reset");
        run_req(2, 1'b0, 0, "down_5_to_2");
        run_req(2, 1'b0, 0, "same_tap");
        run_req(101, 1'b0, 0, "above_max");
        run_req(MAX_TAP, 1'b0, 0, "to_max");
        run_req(0, 1'b1, 0, "load_to_zero");
        run_req(6, 1'b0, 2, "oor_2nd_settle");
        run_req(3, 1'b0, 0, "reload_after_oor");

        // Reset in the middle of a SETTLE window
        launch(20, 1'b0);
        w = 0;
        while (!dl_move && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("midrst_move_seen", 32'(dl_move), 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_pulses", 32'({dl_load, dl_move}), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_cur_valid", 32'(cur_valid), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        m_valid = 1'b0;
`ifdef PF_IO_DLY_CTRL_STATS_EN
        check("midrst_move_cnt", 32'(move_cnt), 32'd0);
        m_moves_total = 0;
        m_errs_total  = 0;
`endif
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            tap = $urandom_range(0, 110);
            ld  = ($urandom_range(0, 3) == 0);
            ok  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            run_req(tap, ld, ok, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
